// File: rtl/foc_pkg.sv
// Shared fixed-point definitions for the FOC datapath: Q15 word type, widths
// of the full-precision products and sums, and the rounding constant.
package foc_pkg;

    localparam int W      = 16;
    localparam int FRAC   = 15;
    localparam int PROD_W = 2 * W;
    localparam int SUM_W  = 2 * W + 1;

    typedef logic signed [W-1:0] q15_t;

    localparam q15_t Q15_ONE = 16'sh7FFF;
    localparam q15_t Q15_MIN = 16'sh8000;

    // Half an output LSB at sum precision; adding it before the shift rounds half-up.
    localparam logic signed [SUM_W-1:0] ROUND_HALF =
        {{(SUM_W - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

    localparam logic signed [SUM_W-1:0] SAT_MAX_WIDE = {{(SUM_W - W){1'b0}}, Q15_ONE};
    localparam logic signed [SUM_W-1:0] SAT_MIN_WIDE = {{(SUM_W - W){1'b1}}, Q15_MIN};

endpackage

// File: rtl/q15_round_sat.sv
// Reduces a full-precision (2W+1)-bit product sum to a Q15 word: round half-up,
// arithmetic shift by FRAC, then clip to the Q15 range and flag the clip.
module q15_round_sat
    import foc_pkg::*;
(
    input  logic signed [SUM_W-1:0] sum,
    output q15_t                    value,
    output logic                    sat
);

    logic signed [SUM_W-1:0] rounded;
    logic signed [SUM_W-1:0] shifted;

    // The sum has headroom above 2^31, so adding the half LSB cannot wrap.
    assign rounded = sum + ROUND_HALF;
    assign shifted = rounded >>> FRAC;

    always_comb begin
        value = shifted[W-1:0];
        sat   = 1'b0;
        if (shifted > SAT_MAX_WIDE) begin
            value = Q15_ONE;
            sat   = 1'b1;
        end else if (shifted < SAT_MIN_WIDE) begin
            value = Q15_MIN;
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/park_transform.sv
// Two-stage Park transform: stage 1 registers the four Q15 x Q15 products,
// stage 2 registers the rounded and saturated d/q sums.
module park_transform
    import foc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] i_alpha,
    input  logic signed [W-1:0] i_beta,
    input  logic signed [W-1:0] sin_theta,
    input  logic signed [W-1:0] cos_theta,
    output logic                out_valid,
    output logic signed [W-1:0] i_d,
    output logic signed [W-1:0] i_q,
    output logic                sat_d,
    output logic                sat_q
);

    logic signed [PROD_W-1:0] p_alpha_sin;
    logic signed [PROD_W-1:0] p_beta_cos;
    logic signed [PROD_W-1:0] p_alpha_cos;
    logic signed [PROD_W-1:0] p_beta_sin;
    logic                     v1;

    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    q15_t                     d_value;
    q15_t                     q_value;
    logic                     d_sat;
    logic                     q_sat;

    // Products are refreshed every cycle; only v1 says whether they matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_alpha_sin <= '0;
            p_beta_cos  <= '0;
            p_alpha_cos <= '0;
            p_beta_sin  <= '0;
            v1          <= 1'b0;
        end else begin
            p_alpha_sin <= i_alpha * sin_theta;
            p_beta_cos  <= i_beta  * cos_theta;
            p_alpha_cos <= i_alpha * cos_theta;
            p_beta_sin  <= i_beta  * sin_theta;
            v1          <= in_valid;
        end
    end

    assign sum_d = {p_alpha_sin[PROD_W-1], p_alpha_sin} + {p_beta_cos[PROD_W-1], p_beta_cos};
    assign sum_q = {p_alpha_cos[PROD_W-1], p_alpha_cos} - {p_beta_sin[PROD_W-1], p_beta_sin};

    q15_round_sat u_round_d (
        .sum   (sum_d),
        .value (d_value),
        .sat   (d_sat)
    );

    q15_round_sat u_round_q (
        .sum   (sum_q),
        .value (q_value),
        .sat   (q_sat)
    );

    // Results and flags hold between valid samples so the PI stage sees a stable value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            i_d       <= '0;
            i_q       <= '0;
            sat_d     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                i_d   <= d_value;
                i_q   <= q_value;
                sat_d <= d_sat;
                sat_q <= q_sat;
            end
        end
    end

endmodule

// File: tb/tb_park_transform.sv
// Self-checking bench for park_transform: integer reference model, per-cycle
// monitor, directed literal cases, random streams, mid-stream reset and a 60 Hz sweep.
module tb_park_transform;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic signed [15:0] i_alpha;
    logic signed [15:0] i_beta;
    logic signed [15:0] sin_theta;
    logic signed [15:0] cos_theta;
    logic        out_valid;
    logic signed [15:0] i_d;
    logic signed [15:0] i_q;
    logic        sat_d;
    logic        sat_q;

    int  checks = 0;
    int  errors = 0;
    bit  sweep_mode = 1'b0;
    int  sweep_outputs = 0;

    park_transform dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .i_alpha   (i_alpha),
        .i_beta    (i_beta),
        .sin_theta (sin_theta),
        .cos_theta (cos_theta),
        .out_valid (out_valid),
        .i_d       (i_d),
        .i_q       (i_q),
        .sat_d     (sat_d),
        .sat_q     (sat_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer sums, round half-up to the nearest Q15 LSB, clip.
    function automatic void model(input int ia, input int ib, input int s, input int c,
                                  output int d, output int q, output bit sd, output bit sq);
        longint sd_full;
        longint sq_full;
        longint rd;
        longint rq;
        sd_full = longint'(ia) * s + longint'(ib) * c;
        sq_full = longint'(ia) * c - longint'(ib) * s;
        rd = (sd_full + 16384) >>> 15;
        rq = (sq_full + 16384) >>> 15;
        sd = (rd > 32767) || (rd < -32768);
        sq = (rq > 32767) || (rq < -32768);
        d  = (rd > 32767) ? 32767 : (rd < -32768) ? -32768 : int'(rd);
        q  = (rq > 32767) ? 32767 : (rq < -32768) ? -32768 : int'(rq);
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    task automatic checkEq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int ia, input int ib, input int s, input int c);
        @(negedge clk);
        i_alpha   = 16'(ia);
        i_beta    = 16'(ib);
        sin_theta = 16'(s);
        cos_theta = 16'(c);
        in_valid  = 1'b1;
    endtask

    // Waits (bounded) for the result of the sample just applied and checks
    // both the literal values and the 2-clock latency.
    task automatic checkOutput(input string name, input int exp_d, input int exp_q,
                               input bit exp_sd, input bit exp_sq);
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no out_valid expected one within 8 clocks", name);
        end else begin
            checkEq({name, "_latency"}, n, 2);
            checkEq({name, "_i_d"}, int'(i_d), exp_d);
            checkEq({name, "_i_q"}, int'(i_q), exp_q);
            checkEq({name, "_sat_d"}, int'(sat_d), int'(exp_sd));
            checkEq({name, "_sat_q"}, int'(sat_q), int'(exp_sq));
        end
    endtask

    // Per-cycle monitor: output after edge k reflects the sample taken at edge k-1.
    initial begin
        bit pv;
        int pd, pq;
        bit psd, psq;
        int hd, hq;
        bit hsd, hsq;
        int nd, nq;
        bit nsd, nsq;
        bit nv;
        pv = 0; pd = 0; pq = 0; psd = 0; psq = 0;
        hd = 0; hq = 0; hsd = 0; hsq = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pv = 0;
                hd = 0; hq = 0; hsd = 0; hsq = 0;
            end else begin
                nv = in_valid;
                model(int'(i_alpha), int'(i_beta), int'(sin_theta), int'(cos_theta),
                      nd, nq, nsd, nsq);
                if (pv) begin
                    hd = pd; hq = pq; hsd = psd; hsq = psq;
                end
                #1;
                checkEq("mon_out_valid", int'(out_valid), int'(pv));
                checkEq("mon_i_d", int'(i_d), hd);
                checkEq("mon_i_q", int'(i_q), hq);
                checkEq("mon_sat_d", int'(sat_d), int'(hsd));
                checkEq("mon_sat_q", int'(sat_q), int'(hsq));
                if (sweep_mode && out_valid) begin
                    sweep_outputs++;
                    checks++;
                    if ((int'(i_d) - 20054 > 3) || (20054 - int'(i_d) > 3) ||
                        (int'(i_q) > 3) || (int'(i_q) < -3)) begin
                        errors++;
                        $display("[TB] FAIL sweep_tolerance: got i_d=%0d i_q=%0d expected 20054+-3 and 0+-3",
                                 i_d, i_q);
                    end
                end
                pv = nv; pd = nd; pq = nq; psd = nsd; psq = nsq;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int md, mq;
        bit msd, msq;
        int ia, ib, s, c;
        real theta;

        rst = 1'b1;
        in_valid = 1'b0;
        i_alpha = '0; i_beta = '0; sin_theta = '0; cos_theta = '0;

        repeat (3) @(negedge clk);
        checkEq("reset_out_valid", int'(out_valid), 0);
        checkEq("reset_i_d", int'(i_d), 0);
        checkEq("reset_i_q", int'(i_q), 0);
        checkEq("reset_sat", int'({sat_d, sat_q}), 0);
        rst = 1'b0;

        // Pin the reference model to hand-computed values.
        model(0, 20054, 0, 32767, md, mq, msd, msq);
        checkEq("model_static_d", md, 20053);
        model(-32768, 32767, 32767, -32768, md, mq, msd, msq);
        checkEq("model_neg_sat_d", md, -32768);
        checkEq("model_neg_q", mq, 2);
        model(-1, 0, 16384, 0, md, mq, msd, msq);
        checkEq("model_round_neg_half", md, 0);

        // Static: i_d=20053, i_q=0, available 2 cycles later.
        applyStimulus(0, 20054, 0, 32767);
        checkOutput("static", 20053, 0, 0, 0);
        applyStimulus(32767, 32767, 32767, 32767);
        checkOutput("sat_pos", 32767, 0, 1, 0);
        // i_q = 2^30 - 32767^2 = 65535 -> 2 after rounding; i_d clips low.
        applyStimulus(-32768, 32767, 32767, -32768);
        checkOutput("sat_neg", -32768, 2, 1, 0);
        applyStimulus(1, 0, 16384, 0);
        checkOutput("round_pos_half", 1, 0, 0, 0);
        applyStimulus(-1, 0, 16384, 0);
        checkOutput("round_neg_half", 0, 0, 0, 0);

        // Random stream with gaps, biased toward full-scale corners.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            i_alpha   = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
            i_beta    = ($urandom_range(0, 7) == 0) ? 16'sh7FFF : 16'($urandom);
            sin_theta = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
            cos_theta = ($urandom_range(0, 7) == 0) ? 16'sh7FFF : 16'($urandom);
        end

        // Mid-stream reset with samples still in flight.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkEq("midreset_out_valid", int'(out_valid), 0);
        checkEq("midreset_i_d", int'(i_d), 0);
        checkEq("midreset_i_q", int'(i_q), 0);
        checkEq("midreset_sat", int'({sat_d, sat_q}), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("post_reset_idle_valid", int'(out_valid), 0);
        applyStimulus(12000, -7000, 23170, 23170);
        model(12000, -7000, 23170, 23170, md, mq, msd, msq);
        checkOutput("post_reset", md, mq, msd, msq);

        // 60 Hz electrical sweep sampled at 20 kHz, amplitude 20054.
        sweep_mode = 1'b1;
        for (int k = 0; k < 1666; k++) begin
            theta = 2.0 * 3.141592653589793 * 60.0 * real'(k) / 20000.0;
            s  = rnd(32767.0 * $sin(theta));
            c  = rnd(32767.0 * $cos(theta));
            ia = rnd(20054.0 * $sin(theta));
            ib = rnd(20054.0 * $cos(theta));
            @(negedge clk);
            in_valid  = 1'b1;
            i_alpha   = 16'(ia);
            i_beta    = 16'(ib);
            sin_theta = 16'(s);
            cos_theta = 16'(c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        sweep_mode = 1'b0;
        checkEq("sweep_output_count", sweep_outputs, 1666);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
